// File: rtl/usb_rx_pkg.sv
// Shared types and default timing constants for the USB receive path.
package usb_rx_pkg;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } timer_state_t;

    localparam int USB_CLKS_PER_BIT  = 8;
    localparam int USB_SAMPLE_PT     = 3;
    localparam int USB_BITS_PER_BYTE = 8;

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter that wraps to 0 after rollover_val and flags the wrap
// with a registered one-cycle pulse.
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             flag_q, flag_d;

    // clear has priority, so a wrap on an abort cycle is never flagged
    always_comb begin
        count_d = count_q;
        flag_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = '0;
                flag_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign rollover_flag = flag_q;

endmodule

// File: rtl/usb_rx_timer.sv
// Bit-timing stage of the USB receiver: re-phases a per-bit clock counter on
// every D+ edge, strobes mid-bit samples and pulses once per completed byte.
module usb_rx_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = USB_CLKS_PER_BIT,
    parameter int SAMPLE_PT     = USB_SAMPLE_PT,
    parameter int BITS_PER_BYTE = USB_BITS_PER_BYTE
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_timer,
    input  logic d_edge,
    input  logic stuff_bit,
    output logic shift_enable,
    output logic byte_received,
    output logic timer_active
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BITS_PER_BYTE + 1);

    localparam logic [CW-1:0] CLK_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_SAMPLE = CW'(SAMPLE_PT);
    localparam logic [CW-1:0] CLK_RELOAD = CW'(1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_BYTE - 1);

    timer_state_t  state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic          sample;
    logic          clear_bits;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        case (state_q)
            TMR_IDLE: begin
                clk_cnt_d = '0;
                if (enable_timer) begin
                    state_d = TMR_RUN;
                end
            end
            TMR_RUN: begin
                // abort beats an edge; an edge beats the increment and the wrap
                if (!enable_timer) begin
                    state_d   = TMR_IDLE;
                    clk_cnt_d = '0;
                end else if (d_edge) begin
                    clk_cnt_d = CLK_RELOAD;
                end else if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = TMR_IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TMR_IDLE;
            clk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
        end
    end

    assign sample       = (state_q == TMR_RUN) && (clk_cnt_q == CLK_SAMPLE);
    assign shift_enable = sample && !stuff_bit;
    assign timer_active = (state_q == TMR_RUN);
    assign clear_bits   = (state_q != TMR_RUN) || !enable_timer;

    flex_counter #(
        .WIDTH(BW)
    ) u_bit_cnt (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear_bits),
        .count_enable (shift_enable),
        .rollover_val (BIT_LAST),
        .rollover_flag(byte_received)
    );

endmodule

// File: tb/tb_usb_rx_timer.sv
// Self-checking bench for usb_rx_timer: directed scenarios then random traffic,
// all checked every cycle against a phase/shift-count reference model.
module tb_usb_rx_timer;

    localparam int CPB = 8;
    localparam int SP  = 3;
    localparam int BPB = 8;

    logic clk;
    logic rst;
    logic enable_timer;
    logic d_edge;
    logic stuff_bit;
    logic shift_enable;
    logic byte_received;
    logic timer_active;

    usb_rx_timer #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_PT    (SP),
        .BITS_PER_BYTE(BPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_timer (enable_timer),
        .d_edge       (d_edge),
        .stuff_bit    (stuff_bit),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .timer_active (timer_active)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: bit phase is (cycle - anchor) mod CPB while running
    int cyc      = 0;
    bit m_run    = 0;
    int anchor   = 0;
    int shifts   = 0;
    bit br_pend  = 0;

    // free-run latency capture
    bit fr_mode  = 0;
    int fr_base  = 0;
    int first_se = -1;
    int first_br = -1;
    int n_br_fr  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic bit model_sample();
        return m_run && (((cyc - anchor) % CPB) == SP);
    endfunction

    function automatic int model_phase();
        return (cyc - anchor) % CPB;
    endfunction

    // one clock: drive inputs, check outputs at negedge, advance model
    task automatic step(input logic en, input logic edg, input logic stf, input logic rs);
        bit exp_se;
        bit br_next;
        rst          = rs;
        enable_timer = en;
        d_edge       = edg;
        stuff_bit    = stf;
        @(negedge clk);
        exp_se = model_sample() && !stf;
        check_eq("timer_active", {31'd0, timer_active}, {31'd0, m_run});
        check_eq("shift_enable", {31'd0, shift_enable}, {31'd0, exp_se});
        check_eq("byte_received", {31'd0, byte_received}, {31'd0, br_pend});
        if (fr_mode) begin
            if (shift_enable === 1'b1 && first_se < 0) first_se = cyc - fr_base;
            if (byte_received === 1'b1) begin
                n_br_fr++;
                if (first_br < 0) first_br = cyc - fr_base;
            end
        end
        br_next = 1'b0;
        if (rs) begin
            m_run  = 0;
            shifts = 0;
        end else if (!m_run) begin
            if (en) begin
                m_run  = 1;
                anchor = cyc + 1;
            end
            shifts = 0;
        end else if (!en) begin
            m_run  = 0;
            shifts = 0;
        end else begin
            if (exp_se) begin
                shifts++;
                if (shifts == BPB) begin
                    shifts  = 0;
                    br_next = 1'b1;
                end
            end
            if (edg) anchor = cyc;
        end
        br_pend = br_next;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_plain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // pulse d_edge on the first running cycle whose phase equals ph
    task automatic edge_at_phase(input int ph);
        bit done;
        done = 0;
        for (int i = 0; i < 3 * CPB && !done; i++) begin
            if (m_run && model_phase() == ph) begin
                step(1'b1, 1'b1, 1'b0, 1'b0);
                done = 1;
            end else begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
            end
        end
        check_eq("edge_placed", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int smp_cnt;
        rst          = 1'b1;
        enable_timer = 1'b1;
        d_edge       = 1'b0;
        stuff_bit    = 1'b0;
        @(posedge clk);
        #1;

        // reset held with enable high and d_edge toggling
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        run_idle(2);

        // free run from enable
        fr_mode = 1;
        fr_base = cyc;
        run_plain(72);
        fr_mode = 0;
        check_eq("first_shift_cycle", first_se, 32'd4);
        check_eq("first_byte_cycle", first_br, 32'd61);
        check_eq("bytes_in_free_run", n_br_fr, 32'd1);

        // resync from phase 6, then edge on a sample cycle
        edge_at_phase(6);
        run_plain(20);
        edge_at_phase(SP);
        run_plain(20);

        // stuffed 4th sample on a fresh packet
        run_idle(3);
        smp_cnt = 0;
        for (int i = 0; i < 90; i++) begin
            if (model_sample()) smp_cnt++;
            step(1'b1, 1'b0, (smp_cnt == 4 && model_sample()), 1'b0);
        end

        // abort after 5 shifts, then re-enable for a full byte
        run_idle(2);
        smp_cnt = 0;
        for (int i = 0; i < 60 && smp_cnt < 5; i++) begin
            if (model_sample()) smp_cnt++;
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        run_idle(3);
        run_plain(80);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 14) == 0),
                 ($urandom_range(0, 399) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
